// File: rtl/ula_controlador_if.sv
// Bundles the request/result handshake and the ULA-side bus of ula_controlador.
// The controller uses the slave modport; the requester/ULA side uses master.
interface ula_controlador_if #(
    parameter int CONT_LARGURA = 8
);
    logic                    Inicio_in;
    logic [7:0]              A_in;
    logic [7:0]              B_in;
    logic                    C_in;
    logic [2:0]              Operacao_in;
    logic                    Usa_Acumulador_in;
    logic                    Ack_in;

    logic [7:0]              ULA_A_out;
    logic [7:0]              ULA_B_out;
    logic                    ULA_C_out;
    logic [2:0]              ULA_Operacao_out;
    logic [7:0]              ULA_Saida_in;
    logic [2:0]              ULA_Flags_in;

    logic                    Pronto_out;
    logic [7:0]              Resultado_out;
    logic [2:0]              Flags_out;
    logic                    Valido_out;
    logic                    Erro_out;
    logic [CONT_LARGURA-1:0] Contador_Ops_out;

    modport slave (
        input  Inicio_in, A_in, B_in, C_in, Operacao_in, Usa_Acumulador_in, Ack_in,
        input  ULA_Saida_in, ULA_Flags_in,
        output ULA_A_out, ULA_B_out, ULA_C_out, ULA_Operacao_out,
        output Pronto_out, Resultado_out, Flags_out, Valido_out, Erro_out, Contador_Ops_out
    );

    modport master (
        output Inicio_in, A_in, B_in, C_in, Operacao_in, Usa_Acumulador_in, Ack_in,
        output ULA_Saida_in, ULA_Flags_in,
        input  ULA_A_out, ULA_B_out, ULA_C_out, ULA_Operacao_out,
        input  Pronto_out, Resultado_out, Flags_out, Valido_out, Erro_out, Contador_Ops_out
    );
endinterface

// File: rtl/ula_controlador.sv
// Sequencer for an external 8-bit ULA: latches a request, holds the ULA inputs for
// LATENCIA cycles, captures result/flags and holds them until acknowledged.
module ula_controlador #(
    parameter int LATENCIA     = 2,
    parameter int CONT_LARGURA = 8
) (
    input  logic             Clock_in,
    input  logic             Reset_n_in,
    ula_controlador_if.slave bus
);
    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA,
        CAPTURA,
        CONCLUIDO,
        ERRO
    } estado_t;

    localparam logic [3:0] ESPERA_INICIAL = 4'(LATENCIA - 1);
    localparam logic [2:0] FLAG_ERRO      = 3'b100;

    estado_t                 estado_q, estado_d;
    logic [3:0]              espera_q, espera_d;
    logic [7:0]              ula_a_q, ula_a_d;
    logic [7:0]              ula_b_q, ula_b_d;
    logic                    ula_c_q, ula_c_d;
    logic [2:0]              ula_op_q, ula_op_d;
    logic [7:0]              resultado_q, resultado_d;
    logic [2:0]              flags_q, flags_d;
    logic [7:0]              acc_q, acc_d;
    logic [CONT_LARGURA-1:0] cont_q, cont_d;

    always_ff @(posedge Clock_in or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            estado_q    <= OCIOSO;
            espera_q    <= '0;
            ula_a_q     <= '0;
            ula_b_q     <= '0;
            ula_c_q     <= 1'b0;
            ula_op_q    <= '0;
            resultado_q <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
            cont_q      <= '0;
        end else begin
            estado_q    <= estado_d;
            espera_q    <= espera_d;
            ula_a_q     <= ula_a_d;
            ula_b_q     <= ula_b_d;
            ula_c_q     <= ula_c_d;
            ula_op_q    <= ula_op_d;
            resultado_q <= resultado_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
            cont_q      <= cont_d;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        espera_d    = espera_q;
        ula_a_d     = ula_a_q;
        ula_b_d     = ula_b_q;
        ula_c_d     = ula_c_q;
        ula_op_d    = ula_op_q;
        resultado_d = resultado_q;
        flags_d     = flags_q;
        acc_d       = acc_q;
        cont_d      = cont_q;

        case (estado_q)
            OCIOSO: begin
                if (bus.Inicio_in) begin
                    ula_a_d  = bus.Usa_Acumulador_in ? acc_q : bus.A_in;
                    ula_b_d  = bus.B_in;
                    ula_c_d  = bus.C_in;
                    ula_op_d = bus.Operacao_in;
                    espera_d = ESPERA_INICIAL;
                    estado_d = ESPERA;
                end
            end
            ESPERA: begin
                if (espera_q == 4'd0) begin
                    estado_d = CAPTURA;
                end else begin
                    espera_d = espera_q - 4'd1;
                end
            end
            CAPTURA: begin
                resultado_d = bus.ULA_Saida_in;
                flags_d     = bus.ULA_Flags_in;
                // An errored operation leaves accumulator and op count untouched.
                if (bus.ULA_Flags_in == FLAG_ERRO) begin
                    estado_d = ERRO;
                end else begin
                    acc_d    = bus.ULA_Saida_in;
                    cont_d   = cont_q + CONT_LARGURA'(1);
                    estado_d = CONCLUIDO;
                end
            end
            CONCLUIDO: begin
                if (bus.Ack_in) estado_d = OCIOSO;
            end
            ERRO: begin
                if (bus.Ack_in) estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    assign bus.ULA_A_out        = ula_a_q;
    assign bus.ULA_B_out        = ula_b_q;
    assign bus.ULA_C_out        = ula_c_q;
    assign bus.ULA_Operacao_out = ula_op_q;
    assign bus.Resultado_out    = resultado_q;
    assign bus.Flags_out        = flags_q;
    assign bus.Contador_Ops_out = cont_q;
    assign bus.Pronto_out       = (estado_q == OCIOSO);
    assign bus.Valido_out       = (estado_q == CONCLUIDO);
    assign bus.Erro_out         = (estado_q == ERRO);
endmodule

// File: tb/tb_ula_controlador.sv
// Directed bench for ula_controlador with a behavioural ULA model driving the
// ULA result/flag inputs from the controller's ULA outputs.
module tb_ula_controlador;
    localparam int LAT = 2;

    logic Clock_in;
    logic Reset_n_in;

    ula_controlador_if #(.CONT_LARGURA(8)) bus ();

    ula_controlador #(.LATENCIA(LAT), .CONT_LARGURA(8)) dut (
        .Clock_in  (Clock_in),
        .Reset_n_in(Reset_n_in),
        .bus       (bus.slave)
    );

    initial Clock_in = 1'b0;
    always #5 Clock_in = ~Clock_in;

    // op 000: add with carry; 110: xor with "nada" flags; 111: forced erro; else and.
    function automatic logic [10:0] ula_model(logic [7:0] a, logic [7:0] b, logic c, logic [2:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic [2:0] f;
        s = {1'b0, a} + {1'b0, b} + {8'd0, c};
        r = s[7:0];
        f = 3'b000;
        case (op)
            3'b000: begin
                if ((a[7] == b[7]) && (r[7] != a[7])) f = 3'b111;
                else if (s[8])                       f = 3'b010;
                else if (r == 8'd0)                  f = 3'b001;
                else                                 f = 3'b000;
            end
            3'b110: begin
                r = a ^ b;
                f = 3'b110;
            end
            3'b111: begin
                r = 8'hEE;
                f = 3'b100;
            end
            default: begin
                r = a & b;
                f = 3'b000;
            end
        endcase
        return {f, r};
    endfunction

    logic [10:0] model_out;
    always_comb begin
        model_out        = ula_model(bus.ULA_A_out, bus.ULA_B_out, bus.ULA_C_out, bus.ULA_Operacao_out);
        bus.ULA_Saida_in = model_out[7:0];
        bus.ULA_Flags_in = model_out[10:8];
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [2:0] op;
        logic       acc;
        logic [7:0] exp_ula_a;
        logic [7:0] exp_res;
        logic [2:0] exp_flags;
        logic       exp_err;
        int         exp_cnt;
    } vec_t;

    vec_t vecs [9];

    // Called at a negedge; returns at the first negedge after the accept edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                            input logic [2:0] op, input logic acc);
        int n;
        n = 0;
        while (!bus.Pronto_out && n < 50) begin
            @(negedge Clock_in);
            n++;
        end
        if (!bus.Pronto_out) check("pronto_timeout", 0, 1);
        bus.A_in              = a;
        bus.B_in              = b;
        bus.C_in              = c;
        bus.Operacao_in       = op;
        bus.Usa_Acumulador_in = acc;
        bus.Inicio_in         = 1'b1;
        @(negedge Clock_in);
        bus.Inicio_in = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!(bus.Valido_out || bus.Erro_out) && lat < 20) begin
            @(negedge Clock_in);
            lat++;
        end
    endtask

    task automatic run_vector(input int i);
        int lat;
        start_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].op, vecs[i].acc);
        check("ula_a_latched", int'(bus.ULA_A_out), int'(vecs[i].exp_ula_a));
        check("ula_b_latched", int'(bus.ULA_B_out), int'(vecs[i].b));
        wait_done(lat);
        check("capture_latency", lat, LAT + 1);
        check("resultado", int'(bus.Resultado_out), int'(vecs[i].exp_res));
        check("flags", int'(bus.Flags_out), int'(vecs[i].exp_flags));
        check("erro", int'(bus.Erro_out), int'(vecs[i].exp_err));
        check("valido", int'(bus.Valido_out), int'(!vecs[i].exp_err));
        check("contador", int'(bus.Contador_Ops_out), vecs[i].exp_cnt);
        bus.Ack_in = 1'b1;
        @(negedge Clock_in);
        bus.Ack_in = 1'b0;
        check("pronto_after_ack", int'(bus.Pronto_out), 1);
        check("accept_to_pronto", lat + 1, LAT + 2);
        check("clear_after_ack", int'(bus.Valido_out | bus.Erro_out), 0);
        $display("[TB] vec %0d a=%0h b=%0h op=%0d acc=%0d -> res=%0h flags=%b cnt=%0d",
                 i, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].acc,
                 bus.Resultado_out, bus.Flags_out, bus.Contador_Ops_out);
    endtask

    initial begin
        int lat;
        int valid_seen;
        int doubles;
        int cnt_bad;
        int saw255;
        logic prev_pronto;
        logic prev_valid;

        vecs[0] = '{8'd100, 8'd27,  1'b0, 3'b000, 1'b0, 8'd100, 8'd127, 3'b000, 1'b0, 1};
        vecs[1] = '{8'd5,   8'd1,   1'b0, 3'b000, 1'b1, 8'd127, 8'd128, 3'b111, 1'b0, 2};
        vecs[2] = '{8'hFF,  8'h01,  1'b0, 3'b000, 1'b0, 8'hFF,  8'h00,  3'b010, 1'b0, 3};
        vecs[3] = '{8'h00,  8'h00,  1'b0, 3'b000, 1'b1, 8'h00,  8'h00,  3'b001, 1'b0, 4};
        vecs[4] = '{8'd3,   8'd4,   1'b0, 3'b111, 1'b0, 8'd3,   8'hEE,  3'b100, 1'b1, 4};
        vecs[5] = '{8'h77,  8'd9,   1'b0, 3'b000, 1'b1, 8'h00,  8'd9,   3'b000, 1'b0, 5};
        vecs[6] = '{8'd10,  8'd5,   1'b1, 3'b000, 1'b0, 8'd10,  8'd16,  3'b000, 1'b0, 6};
        vecs[7] = '{8'h0F,  8'hF0,  1'b0, 3'b110, 1'b0, 8'h0F,  8'hFF,  3'b110, 1'b0, 7};
        vecs[8] = '{8'h00,  8'h01,  1'b0, 3'b000, 1'b1, 8'hFF,  8'h00,  3'b010, 1'b0, 8};

        bus.Inicio_in = 1'b0; bus.A_in = '0; bus.B_in = '0; bus.C_in = 1'b0;
        bus.Operacao_in = '0; bus.Usa_Acumulador_in = 1'b0; bus.Ack_in = 1'b0;
        Reset_n_in = 1'b0;
        repeat (2) @(negedge Clock_in);
        check("rst_pronto", int'(bus.Pronto_out), 1);
        check("rst_valido", int'(bus.Valido_out), 0);
        check("rst_erro", int'(bus.Erro_out), 0);
        check("rst_resultado", int'(bus.Resultado_out), 0);
        check("rst_flags", int'(bus.Flags_out), 0);
        check("rst_contador", int'(bus.Contador_Ops_out), 0);
        check("rst_ula_a", int'(bus.ULA_A_out), 0);
        Reset_n_in = 1'b1;
        @(negedge Clock_in);
        $display("[TB] reset released");

        for (int i = 0; i < 9; i++) run_vector(i);

        // Inputs changing during ESPERA must not reach the ULA.
        start_op(8'h11, 8'h22, 1'b0, 3'b000, 1'b0);
        bus.A_in = 8'hFF;
        check("hold_ula_a_espera", int'(bus.ULA_A_out), 8'h11);
        wait_done(lat);
        check("hold_ula_a_done", int'(bus.ULA_A_out), 8'h11);
        check("hold_resultado", int'(bus.Resultado_out), 8'h33);
        check("hold_contador", int'(bus.Contador_Ops_out), 9);
        bus.Ack_in = 1'b1;
        @(negedge Clock_in);
        bus.Ack_in = 1'b0;
        check("hold_ula_a_ocioso", int'(bus.ULA_A_out), 8'h11);
        $display("[TB] espera hold: ula_a=%0h res=%0h", bus.ULA_A_out, bus.Resultado_out);

        // ERRO ignores Inicio until acknowledged.
        start_op(8'd1, 8'd2, 1'b0, 3'b111, 1'b0);
        wait_done(lat);
        check("err_latency", lat, LAT + 1);
        bus.A_in = 8'h55; bus.Operacao_in = 3'b000; bus.Inicio_in = 1'b1;
        repeat (3) @(negedge Clock_in);
        check("err_sticky", int'(bus.Erro_out), 1);
        check("err_valido", int'(bus.Valido_out), 0);
        check("err_pronto", int'(bus.Pronto_out), 0);
        check("err_ula_a", int'(bus.ULA_A_out), 1);
        check("err_contador", int'(bus.Contador_Ops_out), 9);
        bus.Inicio_in = 1'b0; bus.Ack_in = 1'b1;
        @(negedge Clock_in);
        bus.Ack_in = 1'b0;
        check("err_cleared", int'(bus.Erro_out), 0);
        check("err_pronto_ack", int'(bus.Pronto_out), 1);
        $display("[TB] erro sequence: erro=%0d pronto=%0d", bus.Erro_out, bus.Pronto_out);

        // Asynchronous reset in the middle of ESPERA.
        start_op(8'h40, 8'h02, 1'b0, 3'b000, 1'b0);
        #1 Reset_n_in = 1'b0;
        #1;
        check("async_ula_a", int'(bus.ULA_A_out), 0);
        check("async_resultado", int'(bus.Resultado_out), 0);
        check("async_contador", int'(bus.Contador_Ops_out), 0);
        check("async_pronto", int'(bus.Pronto_out), 1);
        @(negedge Clock_in);
        Reset_n_in = 1'b1;
        repeat (5) @(negedge Clock_in);
        check("async_release_pronto", int'(bus.Pronto_out), 1);
        check("async_discarded", int'(bus.Valido_out), 0);
        $display("[TB] async reset mid-espera");

        // Continuous Inicio with Ack held: no double accept, counter wraps.
        bus.A_in = 8'd1; bus.B_in = 8'd1; bus.Operacao_in = 3'b000; bus.Usa_Acumulador_in = 1'b0;
        bus.Inicio_in = 1'b1; bus.Ack_in = 1'b1;
        valid_seen = 0; doubles = 0; cnt_bad = 0; saw255 = 0;
        prev_pronto = 1'b0; prev_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && valid_seen < 256; cyc++) begin
            @(negedge Clock_in);
            if (bus.Pronto_out && prev_pronto) doubles++;
            if (bus.Valido_out && !prev_valid) begin
                valid_seen++;
                if (int'(bus.Contador_Ops_out) != (valid_seen % 256)) cnt_bad++;
            end
            if (bus.Contador_Ops_out == 8'd255) saw255 = 1;
            prev_pronto = bus.Pronto_out;
            prev_valid  = bus.Valido_out;
        end
        bus.Inicio_in = 1'b0;
        check("cont_ops_seen", valid_seen, 256);
        check("cont_no_double", doubles, 0);
        check("cont_counter_track", cnt_bad, 0);
        check("cont_saw_255", saw255, 1);
        check("cont_wrapped", int'(bus.Contador_Ops_out), 0);
        @(negedge Clock_in);
        bus.Ack_in = 1'b0;
        $display("[TB] continuous: ops=%0d cnt=%0d", valid_seen, bus.Contador_Ops_out);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
